// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes on both sides.
//   Single-cycle logic/arith/shift ops complete one cycle after accept.
//   DIV/MOD run a restoring divider (one quotient bit per cycle) in CALC.
//   The divider is built only when ALU_SEQ_DIV_EN is defined. Otherwise DIV/MOD
//   complete in one cycle with y=0, err=1, and busy is tied low.
// Ports:
//   clk, rst               clock, async active-high reset
//   in_valid/in_ready      operand handshake (a, b, opcode)
//   out_valid/out_ready    result handshake (y, v, z, err)
//   busy                   high while the divider iterates
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             v,
  output logic             z,
  output logic             err,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] OP_DIV = 4'h7;
  localparam logic [3:0] OP_MOD = 4'hA;

  logic [1:0]       state;
  logic             accept;
  logic [WIDTH-1:0] r_y;
  logic             r_v;
  logic             r_err;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);

  // Single-cycle result. For DIV/MOD this is only the b==0 (or disabled) result;
  // a real quotient/remainder comes from the divider.
  always_comb begin
    r_y   = '0;
    r_v   = 1'b0;
    r_err = 1'b0;
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    case (opcode)
      4'h0: r_y = a & b;
      4'h1: r_y = a | b;
      4'h2: r_y = ~a;
      4'h3: r_y = ~(a & b);
      4'h4: r_y = ~(a | b);
      4'h5: r_y = a ^ b;
      4'h6: r_y = ~(a ^ b);
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin r_y = '1; r_err = 1'b1; end
      OP_MOD: begin r_y = a;  r_err = 1'b1; end
`else
      OP_DIV: r_err = 1'b1;
      OP_MOD: r_err = 1'b1;
`endif
      4'h8: {r_v, r_y} = sum;
      4'h9: {r_v, r_y} = diff;   // top bit of the WIDTH+1 difference is the borrow
      4'hB: begin r_y = {a[WIDTH-2:0], 1'b0}; r_v = a[WIDTH-1]; end
      4'hC: r_y = b >> 1;
      4'hD: r_y = {{(WIDTH-1){1'b0}}, (|a) & (|b)};
      4'hE: r_y = {{(WIDTH-1){1'b0}}, (|a) | (|b)};
      4'hF: r_y = {{(WIDTH-1){1'b0}}, &a};
      default: r_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  localparam logic [1:0] CALC = 2'd1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] quo, rem, dvs;
  logic [CW-1:0]    cnt;
  logic             is_mod;
  logic             start_div;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] nquo, nrem, dres;

  assign busy      = (state == CALC);
  assign start_div = accept & ((opcode == OP_DIV) | (opcode == OP_MOD)) & (b != '0);

  // Restoring step: shift the next dividend bit into the partial remainder and
  // subtract the divisor; a clear top bit means the subtraction fits.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  assign ge    = ~trial[WIDTH];
  assign nrem  = ge ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign nquo  = {quo[WIDTH-2:0], ge};
  assign dres  = is_mod ? nrem : nquo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      y      <= '0;
      v      <= 1'b0;
      z      <= 1'b0;
      err    <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      is_mod <= 1'b0;
    end else if (state == CALC) begin
      quo <= nquo;
      rem <= nrem;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        state <= DONE;
        y     <= dres;
        v     <= 1'b0;
        z     <= (dres == '0);
        err   <= 1'b0;
      end
    end else if (accept) begin
      if (start_div) begin
        state  <= CALC;
        quo    <= a;
        rem    <= '0;
        dvs    <= b;
        is_mod <= (opcode == OP_MOD);
        cnt    <= CW'(WIDTH - 1);
      end else begin
        state <= DONE;
        y     <= r_y;
        v     <= r_v;
        z     <= (r_y == '0);
        err   <= r_err;
      end
    end else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      y     <= '0;
      v     <= 1'b0;
      z     <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      state <= DONE;
      y     <= r_y;
      v     <= r_v;
      z     <= (r_y == '0);
      err   <= r_err;
    end else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a WIDTH=4 and a WIDTH=8 instance share clock and reset.
// Expected results are queued per instance at accept and compared at the
// output handshake, together with accept-to-out_valid latency.
module tb_alu_seq;

`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    int y, v, z, err, lat, acc;
  } exp_t;

  typedef struct {
    int op, a, b, y, v, z, err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] iv, ir, ov, ordy, vv, zz, ee, bs;
  logic [3:0] op4, op8, a4, b4, y4;
  logic [7:0] a8, b8, y8;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  exp_t nx [2];
  exp_t sbq [2][$];
  logic [1:0] seen;
  vec_t tbl [21];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a4), .b(b4),
    .opcode(op4), .out_valid(ov[0]), .out_ready(ordy[0]), .y(y4), .v(vv[0]),
    .z(zz[0]), .err(ee[0]), .busy(bs[0])
  );

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a8), .b(b8),
    .opcode(op8), .out_valid(ov[1]), .out_ready(ordy[1]), .y(y8), .v(vv[1]),
    .z(zz[1]), .err(ee[1]), .busy(bs[1])
  );

  function automatic int yout(int d);
    return (d == 0) ? int'(y4) : int'(y8);
  endfunction

  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic int lat_of(int w, int op, int b);
    return (DIV_EN && (op == 7 || op == 10) && b != 0) ? w + 1 : 1;
  endfunction

  // Reference model, plain integer arithmetic masked to w bits.
  function automatic exp_t model(int w, int op, int a, int b);
    exp_t e;
    int m;
    m = (1 << w) - 1;
    e = '{default: 0};
    case (op)
      0: e.y = a & b;
      1: e.y = a | b;
      2: e.y = ~a & m;
      3: e.y = ~(a & b) & m;
      4: e.y = ~(a | b) & m;
      5: e.y = a ^ b;
      6: e.y = ~(a ^ b) & m;
      7: begin
        e.err = (!DIV_EN || b == 0) ? 1 : 0;
        e.y = !DIV_EN ? 0 : (b == 0) ? m : a / b;
      end
      8: begin e.y = (a + b) & m; e.v = ((a + b) >> w) & 1; end
      9: begin e.y = (a - b) & m; e.v = (a < b) ? 1 : 0; end
      10: begin
        e.err = (!DIV_EN || b == 0) ? 1 : 0;
        e.y = !DIV_EN ? 0 : (b == 0) ? a : a % b;
      end
      11: begin e.y = (a << 1) & m; e.v = (a >> (w - 1)) & 1; end
      12: e.y = b >> 1;
      13: e.y = (a != 0 && b != 0) ? 1 : 0;
      14: e.y = (a != 0 || b != 0) ? 1 : 0;
      default: e.y = (a == m) ? 1 : 0;
    endcase
    e.z = (e.y == 0) ? 1 : 0;
    e.lat = lat_of(w, op, b);
    return e;
  endfunction

  // Scoreboard: latency on first out_valid, values at handshake, push on accept.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq[0].delete();
      sbq[1].delete();
      seen = 2'b00;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d] && !seen[d]) begin
          seen[d] = 1'b1;
          chk("sb_nonempty", (sbq[d].size() > 0) ? 1 : 0, 1);
          if (sbq[d].size() > 0) chk("latency", cyc - sbq[d][0].acc, sbq[d][0].lat);
        end
        if (ov[d] && ordy[d] && sbq[d].size() > 0) begin
          e = sbq[d].pop_front();
          chk("y", yout(d), e.y);
          chk("v", int'(vv[d]), e.v);
          chk("z", int'(zz[d]), e.z);
          chk("err", int'(ee[d]), e.err);
          seen[d] = 1'b0;
        end
        if (iv[d] && ir[d]) begin
          e = nx[d];
          e.acc = cyc;
          sbq[d].push_back(e);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(int d, int op, int a, int b);
    int n;
    n = 0;
    iv[d] = 1'b1;
    if (d == 0) begin op4 = 4'(op); a4 = 4'(a); b4 = 4'(b); end
    else begin op8 = 4'(op); a8 = 8'(a); b8 = 8'(b); end
    @(negedge clk);
    while (!ir[d] && n < 50) begin n++; @(negedge clk); end
    if (!ir[d]) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 on dut %0d", d);
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while ((sbq[d].size() > 0 || ov[d]) && n < 100) begin @(posedge clk); n++; end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: dut %0d queue %0d", d, sbq[d].size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, sy, sv, sz, se;
    rst = 1'b1; iv = '0; ordy = 2'b11; seen = '0;
    op4 = '0; a4 = '0; b4 = '0; op8 = '0; a8 = '0; b8 = '0;
    nx[0] = '{default: 0}; nx[1] = '{default: 0};

    tbl = '{
      '{8, 15, 1, 0, 1, 1, 0},   '{9, 3, 5, 14, 1, 0, 0},   '{9, 5, 3, 2, 0, 0, 0},
      '{11, 9, 0, 2, 1, 0, 0},   '{11, 7, 0, 14, 0, 0, 0},  '{0, 12, 10, 8, 0, 0, 0},
      '{1, 12, 3, 15, 0, 0, 0},  '{2, 5, 0, 10, 0, 0, 0},   '{3, 15, 15, 0, 0, 1, 0},
      '{4, 0, 0, 15, 0, 0, 0},   '{5, 6, 3, 5, 0, 0, 0},    '{6, 6, 3, 10, 0, 0, 0},
      '{12, 7, 9, 4, 0, 0, 0},   '{13, 0, 5, 0, 0, 1, 0},   '{14, 0, 5, 1, 0, 0, 0},
      '{15, 15, 0, 1, 0, 0, 0},  '{15, 7, 15, 0, 0, 1, 0},
      '{7, 9, 0, DIV_EN ? 15 : 0, 0, DIV_EN ? 0 : 1, 1},
      '{10, 9, 0, DIV_EN ? 9 : 0, 0, DIV_EN ? 0 : 1, 1},
      '{7, 13, 4, DIV_EN ? 3 : 0, 0, DIV_EN ? 0 : 1, DIV_EN ? 0 : 1},
      '{10, 13, 4, DIV_EN ? 1 : 0, 0, DIV_EN ? 0 : 1, DIV_EN ? 0 : 1}
    };

    repeat (2) @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", int'(ov[d]), 0);
      chk("rst_busy", int'(bs[d]), 0);
      chk("rst_in_ready", int'(ir[d]), 1);
      chk("rst_y", yout(d), 0);
      chk("rst_vzerr", int'({vv[d], zz[d], ee[d]}), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table on the 4-bit instance, issued back to back.
    for (int i = 0; i < 21; i++) begin
      nx[0] = '{y: tbl[i].y, v: tbl[i].v, z: tbl[i].z, err: tbl[i].err,
                lat: lat_of(4, tbl[i].op, tbl[i].b), acc: 0};
      send(0, tbl[i].op, tbl[i].a, tbl[i].b);
    end
    drain(0);

    // Random ops on both widths.
    for (int i = 0; i < 40; i++) begin
      int d, op, a, b;
      d = i % 2;
      op = int'($urandom_range(0, 15));
      a = int'($urandom_range(0, d ? 255 : 15));
      b = int'($urandom_range(0, d ? 255 : 15));
      if ($urandom_range(0, 5) == 0) b = 0;
      nx[d] = model(d ? 8 : 4, op, a, b);
      send(d, op, a, b);
    end
    drain(0);
    drain(1);

    // 8-bit DIV 200/7: busy cycles counted, then MOD and divide by zero.
    nx[1] = '{y: DIV_EN ? 28 : 0, v: 0, z: DIV_EN ? 0 : 1, err: DIV_EN ? 0 : 1,
              lat: DIV_EN ? 9 : 1, acc: 0};
    send(1, 7, 200, 7);
    nb = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ov[1]) break;
      if (bs[1]) nb++;
    end
    chk("div_busy_cycles", nb, DIV_EN ? 8 : 0);
    drain(1);
    nx[1] = '{y: DIV_EN ? 4 : 0, v: 0, z: DIV_EN ? 0 : 1, err: DIV_EN ? 0 : 1,
              lat: DIV_EN ? 9 : 1, acc: 0};
    send(1, 10, 200, 7);
    drain(1);
    nx[1] = '{y: DIV_EN ? 255 : 0, v: 0, z: DIV_EN ? 0 : 1, err: 1, lat: 1, acc: 0};
    send(1, 7, 9, 0);
    drain(1);

    // Stall: result held while out_ready=0, then release with a new op that
    // must be accepted in the releasing cycle.
    ordy[0] = 1'b0;
    nx[0] = '{y: 7, v: 0, z: 0, err: 0, lat: 1, acc: 0};
    send(0, 8, 3, 4);
    @(negedge clk);
    chk("stall_out_valid", int'(ov[0]), 1);
    sy = int'(y4); sv = int'(vv[0]); sz = int'(zz[0]); se = int'(ee[0]);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(ir[0]), 0);
      chk("stall_y", int'(y4), sy);
      chk("stall_vzerr", int'({vv[0], zz[0], ee[0]}), (sv << 2) | (sz << 1) | se);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    nx[0] = '{y: 14, v: 1, z: 0, err: 0, lat: 1, acc: 0};
    iv[0] = 1'b1; op4 = 4'h9; a4 = 4'd3; b4 = 4'd5;
    @(negedge clk);
    chk("release_in_ready", int'(ir[0]), 1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    drain(0);

    // Async reset while the 8-bit instance is mid-operation (CALC when the
    // divider exists, a stalled DONE otherwise).
    ordy[1] = 1'b0;
    nx[1] = '{y: DIV_EN ? 28 : 0, v: 0, z: DIV_EN ? 0 : 1, err: DIV_EN ? 0 : 1,
              lat: DIV_EN ? 9 : 1, acc: 0};
    send(1, 7, 200, 7);
    @(posedge clk); #3;
    chk("pre_rst_busy_or_valid", int'(bs[1] | ov[1]), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(ov[1]), 0);
    chk("async_rst_busy", int'(bs[1]), 0);
    chk("async_rst_in_ready", int'(ir[1]), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    ordy[1] = 1'b1;
    @(posedge clk); #1;
    nx[1] = model(8, 8, 100, 27);
    send(1, 8, 100, 27);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
